// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal/gshare saturating-counter branch predictor
module branch_predictor #(
    parameter int  ENTRIES  = 16,
    parameter int  CNT_BITS = 2,
    parameter int  INIT_CNT = 2 ** (CNT_BITS - 1),
    parameter int  MODE     = 0,
    parameter int  GHR_W    = $clog2(ENTRIES),
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      pred_pc_i,
    output logic             pred_taken_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    input  logic             upd_pred_i,
    output logic             mispredict_o,
    output logic [GHR_W-1:0] ghr_o,
    output logic [31:0]      stat_branches_o,
    output logic [31:0]      stat_mispred_o
);

    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(INIT_CNT);
    localparam logic [31:0]         STAT_MAX = '1;

    logic [CNT_BITS-1:0] cnt_q [ENTRIES];
    logic [CNT_BITS-1:0] upd_cnt;
    logic [CNT_BITS-1:0] upd_cnt_next;
    logic [GHR_W-1:0]    ghr_q;
    logic [IDX_W-1:0]    pred_idx;
    logic [31:0]         branches_q;
    logic [31:0]         mispred_q;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^{pred_pc_i[31:IDX_W+2], pred_pc_i[1:0]};

    // ghr_q is held at zero in bimodal mode, so the XOR degenerates to PC indexing
    assign pred_idx     = pred_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign pred_idx_o   = pred_idx;
    assign pred_taken_o = cnt_q[pred_idx][CNT_BITS-1];
    assign mispredict_o = upd_valid_i & (upd_taken_i != upd_pred_i);
    assign ghr_o        = ghr_q;

    assign upd_cnt = cnt_q[upd_idx_i];

    always_comb begin
        upd_cnt_next = upd_cnt;
        if (upd_taken_i) begin
            if (upd_cnt != CNT_MAX) upd_cnt_next = upd_cnt + 1'b1;
        end else begin
            if (upd_cnt != '0) upd_cnt_next = upd_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
        end else if (upd_valid_i) begin
            cnt_q[upd_idx_i] <= upd_cnt_next;
        end
    end

    generate
        if (MODE == 1) begin : g_gshare
            if (GHR_W == 1) begin : g_ghr1
                always_ff @(posedge clk_i) begin
                    if (rst_i)            ghr_q <= '0;
                    else if (upd_valid_i) ghr_q <= upd_taken_i;
                end
            end else begin : g_ghrn
                always_ff @(posedge clk_i) begin
                    if (rst_i)            ghr_q <= '0;
                    else if (upd_valid_i) ghr_q <= {ghr_q[GHR_W-2:0], upd_taken_i};
                end
            end
        end else begin : g_bimodal
            assign ghr_q = '0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (upd_valid_i && branches_q != STAT_MAX) branches_q <= branches_q + 32'd1;
            if (mispredict_o && mispred_q != STAT_MAX) mispred_q <= mispred_q + 32'd1;
        end
    end

    assign stat_branches_o = branches_q;
    assign stat_mispred_o  = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed bench for branch_predictor (bimodal and gshare instances)
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        upd_valid = 1'b0;
    logic [3:0]  upd_idx = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred = 1'b0;

    logic        b_taken, g_taken, b_misp, g_misp;
    logic [3:0]  b_idx, g_idx, b_ghr, g_ghr;
    logic [31:0] b_br, b_mp, g_br, g_mp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk_i(clk), .rst_i(rst), .pred_pc_i(pc),
        .pred_taken_o(b_taken), .pred_idx_o(b_idx),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx),
        .upd_taken_i(upd_taken), .upd_pred_i(upd_pred),
        .mispredict_o(b_misp), .ghr_o(b_ghr),
        .stat_branches_o(b_br), .stat_mispred_o(b_mp)
    );

    branch_predictor #(.MODE(1), .GHR_W(4)) dut_g (
        .clk_i(clk), .rst_i(rst), .pred_pc_i(pc),
        .pred_taken_o(g_taken), .pred_idx_o(g_idx),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx),
        .upd_taken_i(upd_taken), .upd_pred_i(upd_pred),
        .mispredict_o(g_misp), .ghr_o(g_ghr),
        .stat_branches_o(g_br), .stat_mispred_o(g_mp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        upd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pc = 32'h0000_0040;
        do_reset();
        #1;
        tests++; if (b_taken !== 1'b1) begin fails++; $display("FAIL reset_pred got %b want 1", b_taken); end
        tests++; if (b_idx !== 4'd0) begin fails++; $display("FAIL reset_idx got %h want 0", b_idx); end
        tests++; if (b_ghr !== 4'd0 || g_ghr !== 4'd0) begin fails++; $display("FAIL reset_ghr got %h/%h want 0", b_ghr, g_ghr); end
        tests++; if (b_br !== 32'd0 || b_mp !== 32'd0) begin fails++; $display("FAIL reset_stats got %0d/%0d want 0", b_br, b_mp); end
    endtask

    task automatic test_saturation();
        // expected MSB after each update on idx 3 starting from counter 2
        logic tk [11];
        logic ex [11];
        tk = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        ex = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        do_reset();
        pc = 32'h0000_000C;
        upd_idx = 4'd3;
        upd_pred = 1'b1;
        for (int i = 0; i < 11; i++) begin
            upd_valid = 1'b1;
            upd_taken = tk[i];
            tick();
            upd_valid = 1'b0;
            #1;
            tests++;
            if (b_taken !== ex[i]) begin
                fails++;
                $display("FAIL saturation_step%0d got %b want %b", i, b_taken, ex[i]);
            end
        end
        tests++; if (b_br !== 32'd11) begin fails++; $display("FAIL saturation_branches got %0d want 11", b_br); end
    endtask

    task automatic test_mispredict();
        do_reset();
        upd_idx = 4'd0;
        upd_valid = 1'b1; upd_taken = 1'b0; upd_pred = 1'b1;
        #1;
        tests++; if (b_misp !== 1'b1) begin fails++; $display("FAIL misp_comb got %b want 1", b_misp); end
        tick();
        upd_valid = 1'b0;
        #1;
        tests++; if (b_misp !== 1'b0) begin fails++; $display("FAIL misp_idle got %b want 0", b_misp); end
        tests++; if (b_mp !== 32'd1 || b_br !== 32'd1) begin fails++; $display("FAIL misp_count got %0d/%0d want 1/1", b_mp, b_br); end
        tick();
        tests++; if (b_mp !== 32'd1 || b_br !== 32'd1) begin fails++; $display("FAIL misp_nocount got %0d/%0d want 1/1", b_mp, b_br); end
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pred = 1'b1;
        #1;
        tests++; if (b_misp !== 1'b0) begin fails++; $display("FAIL misp_correct got %b want 0", b_misp); end
        tick();
        upd_valid = 1'b0;
        tests++; if (b_mp !== 32'd1 || b_br !== 32'd2) begin fails++; $display("FAIL misp_correct_count got %0d/%0d want 1/2", b_mp, b_br); end
    endtask

    task automatic test_collision();
        do_reset();
        pc = 32'h0000_0014;
        upd_idx = 4'd5; upd_taken = 1'b0; upd_pred = 1'b1; upd_valid = 1'b1;
        #1;
        tests++; if (b_taken !== 1'b1) begin fails++; $display("FAIL collision_same got %b want 1", b_taken); end
        tick();
        upd_valid = 1'b0;
        #1;
        tests++; if (b_taken !== 1'b0) begin fails++; $display("FAIL collision_next got %b want 0", b_taken); end
    endtask

    task automatic test_gshare();
        logic       tk [4];
        logic [3:0] eg [4];
        tk = '{1, 1, 0, 1};
        eg = '{4'b0001, 4'b0011, 4'b0110, 4'b1101};
        do_reset();
        upd_idx = 4'd9; upd_pred = 1'b0;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1;
            upd_taken = tk[i];
            tick();
            upd_valid = 1'b0;
            tests++;
            if (g_ghr !== eg[i]) begin fails++; $display("FAIL gshare_ghr%0d got %b want %b", i, g_ghr, eg[i]); end
        end
        pc = 32'h0000_0008;
        #1;
        tests++; if (g_idx !== 4'b1111) begin fails++; $display("FAIL gshare_idx got %b want 1111", g_idx); end
        tests++; if (b_idx !== 4'b0010 || b_ghr !== 4'd0) begin fails++; $display("FAIL bimodal_idx got %b ghr %b want 0010/0000", b_idx, b_ghr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pc = 32'h0000_001C;
        upd_idx = 4'd7; upd_pred = 1'b1;
        upd_valid = 1'b1; upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        #1;
        tests++; if (b_taken !== 1'b0) begin fails++; $display("FAIL rstmid_setup got %b want 0", b_taken); end
        rst = 1'b1; upd_valid = 1'b1; upd_taken = 1'b1;
        tick();
        rst = 1'b0; upd_valid = 1'b0;
        #1;
        tests++; if (b_taken !== 1'b1) begin fails++; $display("FAIL rstmid_pred got %b want 1", b_taken); end
        tests++; if (g_ghr !== 4'd0) begin fails++; $display("FAIL rstmid_ghr got %b want 0", g_ghr); end
        tests++; if (b_br !== 32'd0 || b_mp !== 32'd0 || g_br !== 32'd0) begin fails++; $display("FAIL rstmid_stats got %0d/%0d/%0d want 0", b_br, b_mp, g_br); end
        upd_valid = 1'b1; upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        #1;
        tests++; if (b_taken !== 1'b0) begin fails++; $display("FAIL rstmid_cnt2 got %b want 0", b_taken); end
    endtask

    initial begin
        #1;
        test_reset();
        test_saturation();
        test_mispredict();
        test_collision();
        test_gshare();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
